// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the single SRAM port between requester A (ROM-to-RAM loader) and
// requester B (SHA-256 compression core). It also sequences the active-low
// RAM strobes through a fixed IDLE -> SETUP -> STROBE -> HOLD access.
//
// Ports
//   CLK, RST                     clock and synchronous active-high reset
//   A_REQ/A_WE/A_ADDR/A_WDATA    requester A access request (held until A_ACK)
//   A_LOCK                       A keeps tie priority if high during its ACK
//   A_ACK                        one-cycle completion pulse for A
//   B_REQ/B_WE/B_ADDR/B_WDATA    requester B access request (held until B_ACK)
//   B_ACK                        one-cycle completion pulse for B
//   RD_DATA                      registered read data, valid with the ACK
//   RAM_ADDR/RAM_WDATA           RAM address and write data
//   RAM_RDATA                    RAM read data
//   RAM_CE_N/RAM_WE_N/RAM_OE_N   active-low RAM strobes
//   BUSY                         high whenever an access is in flight
module ram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    input  logic              A_LOCK,
    output logic              A_ACK,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_ACK,
    output logic [DATA_W-1:0] RD_DATA,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA,
    output logic              RAM_CE_N,
    output logic              RAM_WE_N,
    output logic              RAM_OE_N,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request: RAM_ADDR and RAM_WDATA double as the address and data
    // latches, so only the direction and the granted port need extra flops.
    logic lat_we;
    logic grant_b;

    // Arbitration history: who was served last, and whether A asked to keep
    // priority on its last ACK.
    logic last_b;
    logic lock_a;

    logic              take;
    logic              sel_b;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              nxt_we;
    logic              ce_n_next;
    logic              we_n_next;
    logic              oe_n_next;

    // Next-state and arbitration. All outputs are registered, so the strobe
    // values are computed here for the state being entered.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        sel_b      = grant_b;

        case (state)
            IDLE: begin
                if (A_REQ || B_REQ) begin
                    take = 1'b1;
                    // On a tie A wins if B went last, or if A went last and
                    // held its lock; otherwise B gets its round-robin turn.
                    if (A_REQ && B_REQ) begin
                        sel_b = !last_b && !lock_a;
                    end else begin
                        sel_b = B_REQ;
                    end
                    state_next = SETUP;
                end
            end
            SETUP:   state_next = STROBE;
            STROBE:  state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        req_we    = sel_b ? B_WE    : A_WE;
        req_addr  = sel_b ? B_ADDR  : A_ADDR;
        req_wdata = sel_b ? B_WDATA : A_WDATA;
        nxt_we    = take ? req_we : lat_we;

        // Output enable opens one cycle early for reads so the RAM output is
        // settled by the time the chip enable closes the STROBE cycle.
        ce_n_next = (state_next != STROBE);
        we_n_next = !((state_next == STROBE) && nxt_we);
        oe_n_next = !(((state_next == SETUP) || (state_next == STROBE)) && !nxt_we);
    end

    // State, latched request, registered outputs and arbitration history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            grant_b   <= 1'b0;
            last_b    <= 1'b1;
            lock_a    <= 1'b0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            RAM_CE_N  <= 1'b1;
            RAM_WE_N  <= 1'b1;
            RAM_OE_N  <= 1'b1;
            RD_DATA   <= '0;
            A_ACK     <= 1'b0;
            B_ACK     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                grant_b   <= sel_b;
                lat_we    <= req_we;
                RAM_ADDR  <= req_addr;
                RAM_WDATA <= req_wdata;
            end
            RAM_CE_N <= ce_n_next;
            RAM_WE_N <= we_n_next;
            RAM_OE_N <= oe_n_next;
            BUSY     <= (state_next != IDLE);
            A_ACK    <= (state_next == HOLD) && !grant_b;
            B_ACK    <= (state_next == HOLD) && grant_b;
            // Read data is taken on the edge that closes STROBE.
            if ((state == STROBE) && !lat_we) begin
                RD_DATA <= RAM_RDATA;
            end
            // A_LOCK is sampled during A's ACK cycle.
            if (state == HOLD) begin
                last_b <= grant_b;
                lock_a <= !grant_b && A_LOCK;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed self-checking bench for ram_arbiter with a behavioural SRAM model.
// Control outputs are checked as the packed vector
// {RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK}.
module tb_ram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    logic              CLK;
    logic              RST;
    logic              A_REQ;
    logic              A_WE;
    logic [ADDR_W-1:0] A_ADDR;
    logic [DATA_W-1:0] A_WDATA;
    logic              A_LOCK;
    logic              A_ACK;
    logic              B_REQ;
    logic              B_WE;
    logic [ADDR_W-1:0] B_ADDR;
    logic [DATA_W-1:0] B_WDATA;
    logic              B_ACK;
    logic [DATA_W-1:0] RD_DATA;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_WDATA;
    logic [DATA_W-1:0] RAM_RDATA;
    logic              RAM_CE_N;
    logic              RAM_WE_N;
    logic              RAM_OE_N;
    logic              BUSY;

    int n_checks;
    int n_fail;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_LOCK(A_LOCK), .A_ACK(A_ACK),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_ACK(B_ACK), .RD_DATA(RD_DATA),
        .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA),
        .RAM_CE_N(RAM_CE_N), .RAM_WE_N(RAM_WE_N), .RAM_OE_N(RAM_OE_N),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model: writes land mid-cycle while both strobes are low, reads
    // only return data while chip and output enables are both active.
    always @(negedge CLK) begin
        if (!RAM_CE_N && !RAM_WE_N) mem[RAM_ADDR] <= RAM_WDATA;
    end
    assign RAM_RDATA = (!RAM_CE_N && !RAM_OE_N) ? mem[RAM_ADDR] : 32'h0BAD_0BAD;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = '0; A_WDATA = '0; A_LOCK = 1'b0;
        B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = '0; B_WDATA = '0;
        tick();
        tick();
        RST = 1'b0;
        n_checks++;
        if ({RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK} !== 6'b111000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK}, 6'b111000);
        end
        n_checks++;
        if (RAM_ADDR !== 15'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_addr: got %h expected %h", RAM_ADDR, 15'h0);
        end
        n_checks++;
        if (RD_DATA !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_rd_data: got %h expected %h", RD_DATA, 32'h0);
        end
    endtask

    task automatic test_single_write();
        logic [5:0] exp [4];
        exp = '{6'b111100, 6'b001100, 6'b111110, 6'b111000};
        A_WE = 1'b1; A_ADDR = 15'h0010; A_WDATA = 32'hDEADBEEF; A_REQ = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            if (cyc == 3) A_REQ = 1'b0;
            n_checks++;
            if ({RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK} !== exp[cyc-1]) begin
                n_fail++;
                $display("[TB] FAIL write_ctrl cyc%0d: got %b expected %b", cyc,
                         {RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK}, exp[cyc-1]);
            end
            n_checks++;
            if (RAM_ADDR !== 15'h0010) begin
                n_fail++;
                $display("[TB] FAIL write_addr cyc%0d: got %h expected %h", cyc, RAM_ADDR, 15'h0010);
            end
        end
        n_checks++;
        if (mem[15'h0010] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL write_ram_content: got %h expected %h", mem[15'h0010], 32'hDEADBEEF);
        end
    endtask

    task automatic test_single_read();
        logic [5:0] exp [4];
        exp = '{6'b110100, 6'b010100, 6'b111101, 6'b111000};
        B_WE = 1'b0; B_ADDR = 15'h0010; B_REQ = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            if (cyc == 3) begin
                B_REQ = 1'b0;
                n_checks++;
                if (RD_DATA !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("[TB] FAIL read_data: got %h expected %h", RD_DATA, 32'hDEADBEEF);
                end
            end
            n_checks++;
            if ({RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK} !== exp[cyc-1]) begin
                n_fail++;
                $display("[TB] FAIL read_ctrl cyc%0d: got %b expected %b", cyc,
                         {RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK}, exp[cyc-1]);
            end
        end
    endtask

    // A keeps REQ high through the IDLE after its ACK and gets a duplicate.
    task automatic test_back_to_back();
        logic [1:0] exp [8];
        exp = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00};
        A_WE = 1'b1; A_ADDR = 15'h0050; A_WDATA = 32'h55AA55AA; A_REQ = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cyc == 5) A_REQ = 1'b0;
            n_checks++;
            if ({BUSY, A_ACK} !== exp[cyc-1]) begin
                n_fail++;
                $display("[TB] FAIL dup_busy_ack cyc%0d: got %b expected %b", cyc, {BUSY, A_ACK}, exp[cyc-1]);
            end
            if (cyc == 7) begin
                n_checks++;
                if (RD_DATA !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("[TB] FAIL dup_rd_data_kept: got %h expected %h", RD_DATA, 32'hDEADBEEF);
                end
            end
        end
        n_checks++;
        if (mem[15'h0050] !== 32'h55AA55AA) begin
            n_fail++;
            $display("[TB] FAIL dup_ram_content: got %h expected %h", mem[15'h0050], 32'h55AA55AA);
        end
    endtask

    // Both requesters held from reset: round-robin starting with A.
    task automatic test_contention();
        logic [2:0]        exp;
        logic [ADDR_W-1:0] exp_addr;
        A_WE = 1'b1; A_ADDR = 15'h0030; A_WDATA = 32'hAAAA0030;
        B_WE = 1'b1; B_ADDR = 15'h0031; B_WDATA = 32'hBBBB0031;
        RST = 1'b1; A_REQ = 1'b1; B_REQ = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if ({BUSY, RAM_ADDR} !== {1'b0, 15'h0000}) begin
            n_fail++;
            $display("[TB] FAIL rr_reset_wins: got busy=%b addr=%h expected busy=0 addr=0000", BUSY, RAM_ADDR);
        end
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            case (cyc)
                3, 11:   exp = 3'b110;
                7, 15:   exp = 3'b101;
                4, 8, 12, 16: exp = 3'b000;
                default: exp = 3'b100;
            endcase
            if (cyc == 15) begin
                A_REQ = 1'b0;
                B_REQ = 1'b0;
            end
            n_checks++;
            if ({BUSY, A_ACK, B_ACK} !== exp) begin
                n_fail++;
                $display("[TB] FAIL rr_busy_acks cyc%0d: got %b expected %b", cyc, {BUSY, A_ACK, B_ACK}, exp);
            end
            if ((cyc % 4) == 1) begin
                exp_addr = ((cyc % 8) == 1) ? 15'h0030 : 15'h0031;
                n_checks++;
                if (RAM_ADDR !== exp_addr) begin
                    n_fail++;
                    $display("[TB] FAIL rr_grant_addr cyc%0d: got %h expected %h", cyc, RAM_ADDR, exp_addr);
                end
            end
        end
    endtask

    // A_LOCK keeps A in front for three grants, then B reads 0x0010.
    task automatic test_lock();
        logic [1:0] exp;
        A_WE = 1'b1; A_ADDR = 15'h0040; A_WDATA = 32'h40404040; A_LOCK = 1'b1;
        B_WE = 1'b0; B_ADDR = 15'h0010;
        A_REQ = 1'b1; B_REQ = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            case (cyc)
                3, 7, 11: exp = 2'b10;
                15:       exp = 2'b01;
                default:  exp = 2'b00;
            endcase
            if (cyc == 11) A_LOCK = 1'b0;
            if (cyc == 15) begin
                A_REQ = 1'b0;
                B_REQ = 1'b0;
                n_checks++;
                if (RD_DATA !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("[TB] FAIL lock_b_read: got %h expected %h", RD_DATA, 32'hDEADBEEF);
                end
            end
            n_checks++;
            if ({A_ACK, B_ACK} !== exp) begin
                n_fail++;
                $display("[TB] FAIL lock_acks cyc%0d: got %b expected %b", cyc, {A_ACK, B_ACK}, exp);
            end
        end
    endtask

    // Reset lands during STROBE of a write; a fresh request then completes.
    task automatic test_reset_mid_strobe();
        logic [1:0] exp [4];
        exp = '{2'b10, 2'b10, 2'b11, 2'b00};
        A_WE = 1'b1; A_ADDR = 15'h0020; A_WDATA = 32'h12345678; A_REQ = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK} !== 6'b001100) begin
            n_fail++;
            $display("[TB] FAIL abort_strobe_ctrl: got %b expected %b",
                     {RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK}, 6'b001100);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if ({RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK} !== 6'b111000) begin
            n_fail++;
            $display("[TB] FAIL abort_ctrl: got %b expected %b",
                     {RAM_CE_N, RAM_WE_N, RAM_OE_N, BUSY, A_ACK, B_ACK}, 6'b111000);
        end
        n_checks++;
        if ({RAM_ADDR, RD_DATA} !== {15'h0000, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL abort_addr_rd: got addr=%h rd=%h expected addr=0000 rd=00000000", RAM_ADDR, RD_DATA);
        end
        A_ADDR = 15'h0021; A_WDATA = 32'hCAFEF00D;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            if (cyc == 3) A_REQ = 1'b0;
            n_checks++;
            if ({BUSY, A_ACK} !== exp[cyc-1]) begin
                n_fail++;
                $display("[TB] FAIL abort_retry cyc%0d: got %b expected %b", cyc, {BUSY, A_ACK}, exp[cyc-1]);
            end
        end
        n_checks++;
        if (mem[15'h0021] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("[TB] FAIL abort_retry_ram: got %h expected %h", mem[15'h0021], 32'hCAFEF00D);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_contention();
        test_lock();
        test_reset_mid_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
